mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between three requesters: data port (stage 4a load/store), fetch port (stage 1a instruction fetch) and debug/loader port (program load and inspection).
- Fixed-priority arbitration (data > fetch > debug) with a starvation boost for debug.
- Tracks in-flight reads in a latency-matched tag pipeline so returned data is steered to the correct requester.
- Drives the fetch stall consumed by the front-end stall logic.

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter sharing one single-port synchronous memory between the data,
// fetch and debug ports, with a debug starvation boost and a tag pipeline for read return.
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_rvalid,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_stall,
    output logic              f_rvalid,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [31:0]       g_wdata,
    output logic              g_gnt,
    output logic              g_rvalid,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [1:0] ID_DATA  = 2'd0;
    localparam logic [1:0] ID_FETCH = 2'd1;
    localparam logic [1:0] ID_DEBUG = 2'd2;

    logic [CNT_W-1:0] count_reg, count_next;
    logic             boost_reg;
    logic             data_win, fetch_win, debug_win, read_issue;
    logic [1:0]       win_id;

    logic [READ_LATENCY-1:0]       tag_valid_reg, tag_valid_next;
    logic [READ_LATENCY-1:0][1:0]  tag_id_reg, tag_id_next;

    // Grants are qualified by reset so nothing reaches the memory while it is held.
    always_comb begin
        data_win  = reset & d_req;
        debug_win = reset & ~d_req & g_req & (boost_reg | ~f_req);
        fetch_win = reset & ~d_req & f_req & ~(boost_reg & g_req);
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        win_id    = ID_DATA;
        if (data_win) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_we ? d_be : 4'hF;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            win_id    = ID_DATA;
        end else if (debug_win) begin
            mem_en    = 1'b1;
            mem_we    = g_we;
            mem_be    = 4'hF;
            mem_addr  = g_addr;
            mem_wdata = g_wdata;
            win_id    = ID_DEBUG;
        end else if (fetch_win) begin
            mem_en    = 1'b1;
            mem_be    = 4'hF;
            mem_addr  = f_addr;
            win_id    = ID_FETCH;
        end
    end

    assign read_issue = mem_en & ~mem_we;
    assign f_stall    = f_req & reset & ~fetch_win;
    assign g_gnt      = debug_win;

    always_comb begin
        count_next = '0;
        if (g_req && !debug_win) begin
            count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;
        end
    end

    // Boost is registered from the next count so it is live in the cycle the count reaches the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            boost_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            boost_reg <= (count_next == CNT_MAX);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_tag_stage
            if (gi == 0) begin : g_head
                assign tag_valid_next[gi] = read_issue;
                assign tag_id_next[gi]    = win_id;
            end else begin : g_body
                assign tag_valid_next[gi] = tag_valid_reg[gi-1];
                assign tag_id_next[gi]    = tag_id_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_id_reg    <= tag_id_next;
        end
    end

    assign d_rvalid = tag_valid_reg[READ_LATENCY-1] & (tag_id_reg[READ_LATENCY-1] == ID_DATA);
    assign f_rvalid = tag_valid_reg[READ_LATENCY-1] & (tag_id_reg[READ_LATENCY-1] == ID_FETCH);
    assign g_rvalid = tag_valid_reg[READ_LATENCY-1] & (tag_id_reg[READ_LATENCY-1] == ID_DEBUG);
    assign rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed multi-cycle sequences and a
// scoreboarded random stream against a two-cycle synchronous memory model.
module tb_mem_port_arbiter;

    localparam int AW  = 12;
    localparam int LIM = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          d_req, d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_rvalid;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_stall, f_rvalid;
    logic          g_req, g_we;
    logic [AW-1:0] g_addr;
    logic [31:0]   g_wdata;
    logic          g_gnt, g_rvalid;
    logic [31:0]   rdata;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int errors;
    int checks;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(AW), .READ_LATENCY(2), .STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid),
        .f_req(f_req), .f_addr(f_addr), .f_stall(f_stall), .f_rvalid(f_rvalid),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_gnt(g_gnt), .g_rvalid(g_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port synchronous memory, two-cycle read latency, zeroed at start.
    logic [31:0] mem_arr [0:4095] = '{default: 32'h0};
    logic [31:0] rd_p1 = 32'h0;
    logic [31:0] rd_p2 = 32'h0;
    always @(posedge clock) begin
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_en && !mem_we) rd_p1 <= mem_arr[mem_addr];
        rd_p2 <= rd_p1;
    end
    assign mem_rdata = rd_p2;

    typedef struct {
        logic          d_req, d_we;
        logic [3:0]    d_be;
        logic [AW-1:0] d_addr;
        logic [31:0]   d_wdata;
        logic          f_req;
        logic [AW-1:0] f_addr;
        logic          g_req, g_we;
        logic [AW-1:0] g_addr;
        logic [31:0]   g_wdata;
        logic          e_en, e_we;
        logic [3:0]    e_be;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wdata;
        logic          e_stall, e_gnt;
    } vec_t;

    typedef struct {
        int         due;
        logic [2:0] port;
        logic [31:0] data;
    } rd_t;

    vec_t vecs [10];
    rd_t  rq [$];
    logic [31:0] ref_mem [0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
        f_req = 1'b0; f_addr = '0;
        g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
    endtask

    task automatic check_no_rvalid(input string name);
        check(name, 32'({g_rvalid, f_rvalid, d_rvalid}), 32'h0);
    endtask

    initial begin
        int c;
        logic boost_m, g_pend;
        logic [1:0] win;
        logic [2:0] exp_rv;
        logic [3:0] be_m;

        errors = 0;
        checks = 0;
        reset  = 1'b0;
        idle();

        vecs[0] = '{1'b0,1'b0,4'h0,12'h000,32'h0, 1'b0,12'h000, 1'b0,1'b0,12'h000,32'h0,
                    1'b0,1'b0,4'h0,12'h000,32'h0, 1'b0,1'b0};
        vecs[1] = '{1'b0,1'b0,4'h0,12'h000,32'h0, 1'b1,12'h004, 1'b0,1'b0,12'h000,32'h0,
                    1'b1,1'b0,4'hF,12'h004,32'h0, 1'b0,1'b0};
        vecs[2] = '{1'b1,1'b1,4'h5,12'h030,32'hA5A55A5A, 1'b1,12'h004, 1'b0,1'b0,12'h000,32'h0,
                    1'b1,1'b1,4'h5,12'h030,32'hA5A55A5A, 1'b1,1'b0};
        vecs[3] = '{1'b1,1'b0,4'h5,12'h031,32'h12345678, 1'b0,12'h000, 1'b0,1'b0,12'h000,32'h0,
                    1'b1,1'b0,4'hF,12'h031,32'h0, 1'b0,1'b0};
        vecs[4] = '{1'b0,1'b0,4'h0,12'h000,32'h0, 1'b0,12'h000, 1'b1,1'b1,12'h200,32'hCAFEF00D,
                    1'b1,1'b1,4'hF,12'h200,32'hCAFEF00D, 1'b0,1'b1};
        vecs[5] = '{1'b0,1'b0,4'h0,12'h000,32'h0, 1'b1,12'h008, 1'b1,1'b0,12'h201,32'h0,
                    1'b1,1'b0,4'hF,12'h008,32'h0, 1'b0,1'b0};
        vecs[6] = '{1'b1,1'b0,4'h0,12'h032,32'h0, 1'b0,12'h000, 1'b1,1'b0,12'h201,32'h0,
                    1'b1,1'b0,4'hF,12'h032,32'h0, 1'b0,1'b0};
        vecs[7] = '{1'b1,1'b1,4'hF,12'h033,32'h00000001, 1'b1,12'h00C, 1'b1,1'b0,12'h201,32'h0,
                    1'b1,1'b1,4'hF,12'h033,32'h00000001, 1'b1,1'b0};
        vecs[8] = '{1'b0,1'b0,4'h0,12'h000,32'h0, 1'b0,12'h000, 1'b1,1'b0,12'h201,32'h0,
                    1'b1,1'b0,4'hF,12'h201,32'h0, 1'b0,1'b1};
        vecs[9] = vecs[0];

        // Held in reset with every port requesting: nothing reaches the memory.
        repeat (2) @(posedge clock);
        #1;
        d_req = 1'b1; f_req = 1'b1; g_req = 1'b1;
        #3;
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_gnt_stall", 32'({g_gnt, f_stall}), 32'h0);
        check_no_rvalid("rst_rvalid");
        idle();
        tick();
        reset = 1'b1;

        foreach (vecs[i]) begin
            d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_be = vecs[i].d_be;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            f_req = vecs[i].f_req; f_addr = vecs[i].f_addr;
            g_req = vecs[i].g_req; g_we = vecs[i].g_we; g_addr = vecs[i].g_addr;
            g_wdata = vecs[i].g_wdata;
            #3;
            check($sformatf("vec%0d_en", i), 32'(mem_en), 32'(vecs[i].e_en));
            check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_be", i), 32'(mem_be), 32'(vecs[i].e_be));
            if (vecs[i].e_en)
                check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            if (vecs[i].e_we)
                check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
            check($sformatf("vec%0d_stall", i), 32'(f_stall), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d_gnt", i), 32'(g_gnt), 32'(vecs[i].e_gnt));
            $display("vec %0d: d=%b f=%b g=%b -> en=%b we=%b be=%h addr=%h stall=%b gnt=%b",
                     i, d_req, f_req, g_req, mem_en, mem_we, mem_be, mem_addr, f_stall, g_gnt);
            tick();
        end
        idle();
        repeat (3) tick();

        // Reset arriving while a fetch read is in flight discards it.
        f_req = 1'b1; f_addr = 12'h010;
        #3;
        check("inflight_issue", 32'(mem_addr), 32'h010);
        tick();
        reset = 1'b0;
        #3;
        check("inflight_rst_en", 32'(mem_en), 32'h0);
        check("inflight_rst_stall", 32'(f_stall), 32'h0);
        tick();
        reset = 1'b1;
        f_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #3;
            check($sformatf("inflight_norv%0d", k), 32'({g_rvalid, f_rvalid, d_rvalid}), 32'h0);
            tick();
        end
        $display("seq reset-inflight done");

        // Data beats fetch; both reads return back to back in issue order.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 12'h020; d_wdata = 32'h11112222;
        tick();
        d_addr = 12'h004; d_wdata = 32'h33334444;
        tick();
        d_we = 1'b0; d_addr = 12'h020; f_req = 1'b1; f_addr = 12'h004;
        #3;
        check("dof_addr_d", 32'(mem_addr), 32'h020);
        check("dof_stall", 32'(f_stall), 32'h1);
        tick();
        d_req = 1'b0;
        #3;
        check("dof_addr_f", 32'(mem_addr), 32'h004);
        check("dof_nostall", 32'(f_stall), 32'h0);
        tick();
        f_req = 1'b0;
        #3;
        check("dof_rv_d", 32'({g_rvalid, f_rvalid, d_rvalid}), 32'h1);
        check("dof_rdata_d", rdata, 32'h11112222);
        tick();
        #3;
        check("dof_rv_f", 32'({g_rvalid, f_rvalid, d_rvalid}), 32'h2);
        check("dof_rdata_f", rdata, 32'h33334444);
        tick();
        $display("seq data-over-fetch done");

        // Byte-enabled write: only the low half lands, no rvalid for the write.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 12'h040; d_wdata = 32'hDEADBEEF;
        #3;
        check("bw_we", 32'(mem_we), 32'h1);
        check("bw_be", 32'(mem_be), 32'h3);
        tick();
        d_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #3;
            check($sformatf("bw_norv%0d", k), 32'({g_rvalid, f_rvalid, d_rvalid}), 32'h0);
            tick();
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h040;
        tick();
        d_req = 1'b0;
        tick();
        #3;
        check("bw_rv", 32'({g_rvalid, f_rvalid, d_rvalid}), 32'h1);
        check("bw_rdata", rdata, 32'h0000BEEF);
        tick();
        $display("seq byte-write done");

        // Fetch held: debug granted in the ninth cycle of its request.
        f_req = 1'b1; f_addr = 12'h050;
        g_req = 1'b1; g_we = 1'b0; g_addr = 12'h100;
        for (int k = 1; k <= LIM + 1; k++) begin
            #3;
            check($sformatf("starve_gnt%0d", k), 32'(g_gnt), 32'(k == LIM + 1));
            check($sformatf("starve_stall%0d", k), 32'(f_stall), 32'(k == LIM + 1));
            if (k == LIM + 1) check("starve_addr", 32'(mem_addr), 32'h100);
            tick();
        end
        g_req = 1'b0;
        #3;
        check("starve_after_gnt", 32'(g_gnt), 32'h0);
        check("starve_after_addr", 32'(mem_addr), 32'h050);
        tick();
        #3;
        check("starve_grv", 32'(g_rvalid), 32'h1);
        check("starve_frv", 32'(f_rvalid), 32'h0);
        tick();
        $display("seq starvation-boost done");

        // Boost reached, data keeps the port for three cycles, debug takes the next one.
        g_req = 1'b1; g_addr = 12'h102;
        for (int k = 1; k <= LIM; k++) begin
            #3;
            check($sformatf("bvd_pre%0d", k), 32'(g_gnt), 32'h0);
            tick();
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h060;
        for (int k = 0; k < 3; k++) begin
            #3;
            check($sformatf("bvd_data_gnt%0d", k), 32'(g_gnt), 32'h0);
            check($sformatf("bvd_data_addr%0d", k), 32'(mem_addr), 32'h060);
            tick();
        end
        d_req = 1'b0;
        #3;
        check("bvd_gnt", 32'(g_gnt), 32'h1);
        check("bvd_stall", 32'(f_stall), 32'h1);
        check("bvd_addr", 32'(mem_addr), 32'h102);
        tick();
        g_req = 1'b0;
        tick();
        $display("seq boost-vs-data done");

        // Boost is lost once debug drops its request.
        g_req = 1'b1; g_addr = 12'h103;
        repeat (LIM) tick();
        g_req = 1'b0;
        #3;
        check("bdrop_fetch", 32'(mem_addr), 32'h050);
        tick();
        g_req = 1'b1;
        #3;
        check("bdrop_gnt", 32'(g_gnt), 32'h0);
        check("bdrop_stall", 32'(f_stall), 32'h0);
        tick();
        idle();
        repeat (4) tick();
        $display("seq boost-drop done");

        // Random stream in a fresh address window against a scoreboard.
        for (int a = 0; a < 16; a++) ref_mem[a] = 32'h0;
        c = 0;
        g_pend = 1'b0;
        for (int cyc = 0; cyc < 10003; cyc++) begin
            if (cyc < 10000) begin
                d_req   = ($urandom_range(0, 99) < 30);
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom_range(0, 15));
                d_addr  = 12'h800 | 12'($urandom_range(0, 15));
                d_wdata = $urandom;
                f_req   = ($urandom_range(0, 99) < 50);
                f_addr  = 12'h800 | 12'($urandom_range(0, 15));
                if (!g_pend && $urandom_range(0, 99) < 25) begin
                    g_pend  = 1'b1;
                    g_we    = 1'($urandom_range(0, 1));
                    g_addr  = 12'h800 | 12'($urandom_range(0, 15));
                    g_wdata = $urandom;
                end
            end else begin
                d_req = 1'b0; f_req = 1'b0; g_pend = 1'b0;
            end
            g_req = g_pend;

            boost_m = (c == LIM);
            if (d_req)                 win = 2'd1;
            else if (boost_m && g_req) win = 2'd3;
            else if (f_req)            win = 2'd2;
            else if (g_req)            win = 2'd3;
            else                       win = 2'd0;

            #3;
            check("rnd_en", 32'(mem_en), 32'(win != 2'd0));
            check("rnd_gnt", 32'(g_gnt), 32'(win == 2'd3));
            check("rnd_stall", 32'(f_stall), 32'(f_req && win != 2'd2));
            case (win)
                2'd1: check("rnd_addr", 32'(mem_addr), 32'(d_addr));
                2'd2: check("rnd_addr", 32'(mem_addr), 32'(f_addr));
                2'd3: check("rnd_addr", 32'(mem_addr), 32'(g_addr));
                default: ;
            endcase

            exp_rv = 3'b000;
            if (rq.size() > 0 && rq[0].due == cyc) exp_rv = rq[0].port;
            check("rnd_rvalid", 32'({g_rvalid, f_rvalid, d_rvalid}), 32'(exp_rv));
            if (exp_rv != 3'b000) begin
                check("rnd_rdata", rdata, rq[0].data);
                void'(rq.pop_front());
            end

            if (win == 2'd1 && !d_we)
                rq.push_back('{cyc + 2, 3'b001, ref_mem[d_addr[3:0]]});
            else if (win == 2'd2)
                rq.push_back('{cyc + 2, 3'b010, ref_mem[f_addr[3:0]]});
            else if (win == 2'd3 && !g_we)
                rq.push_back('{cyc + 2, 3'b100, ref_mem[g_addr[3:0]]});
            if (win == 2'd1 && d_we) begin
                be_m = d_be;
                for (int b = 0; b < 4; b++)
                    if (be_m[b]) ref_mem[d_addr[3:0]][8*b +: 8] = d_wdata[8*b +: 8];
            end else if (win == 2'd3 && g_we) begin
                ref_mem[g_addr[3:0]] = g_wdata;
            end

            if (g_req && win != 2'd3) c = (c == LIM) ? LIM : c + 1;
            else                       c = 0;
            if (win == 2'd3) g_pend = 1'b0;
            tick();
        end
        check("rnd_queue_empty", 32'(rq.size()), 32'h0);
        $display("seq random-stream done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
